// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: parses header/operand byte pairs into ALU ops,
// issues them with a valid/ready handshake and tracks results.
module alu_op_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [2:0] out_a,
  output logic [2:0] out_b,
  output logic [1:0] out_opcode,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic [3:0] alu_z,
  output logic [3:0] last_result,
  output logic [7:0] issue_count,
  output logic       err
);

  typedef enum logic [1:0] {
    HDR   = 2'd0,
    OPND  = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t     state;
  state_t     nxt;
  logic [1:0] op_q;
  logic       chain_q;
  logic [3:0] idle;

  logic acc;
  logic hdr_ok;
  logic ld_hdr;
  logic ld_opnd;
  logic bad_hdr;
  logic tmo;
  logic idle_inc;
  logic fire;

  assign in_ready  = rst_n && (state != ISSUE);
  assign out_valid = (state == ISSUE);
  assign acc       = in_valid && in_ready;
  assign hdr_ok    = (in_data[4:0] == 5'd0);

  // Next-state and per-cycle control decode
  always_comb begin
    nxt      = state;
    ld_hdr   = 1'b0;
    ld_opnd  = 1'b0;
    bad_hdr  = 1'b0;
    tmo      = 1'b0;
    idle_inc = 1'b0;
    fire     = 1'b0;
    unique case (state)
      HDR: begin
        if (acc) begin
          if (hdr_ok) begin
            ld_hdr = 1'b1;
            nxt    = OPND;
          end else begin
            bad_hdr = 1'b1;
          end
        end
      end
      OPND: begin
        if (acc) begin
          ld_opnd = 1'b1;
          nxt     = ISSUE;
        end else if (idle == 4'd14) begin
          tmo = 1'b1;
          nxt = HDR;
        end else begin
          idle_inc = 1'b1;
        end
      end
      ISSUE: begin
        if (out_ready) begin
          fire = 1'b1;
          nxt  = HDR;
        end
      end
      default: nxt = HDR;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HDR;
    else        state <= nxt;
  end

  // Command latches, operand outputs, result tracking and error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= 2'd0;
      chain_q     <= 1'b0;
      idle        <= 4'd0;
      out_a       <= 3'd0;
      out_b       <= 3'd0;
      out_opcode  <= 2'd0;
      last_result <= 4'd0;
      issue_count <= 8'd0;
      err         <= 1'b0;
    end else begin
      err <= bad_hdr | tmo;
      if (ld_hdr) begin
        op_q    <= in_data[7:6];
        chain_q <= in_data[5];
        idle    <= 4'd0;
      end else if (idle_inc) begin
        idle <= idle + 4'd1;
      end else if (tmo) begin
        idle <= 4'd0;
      end
      if (ld_opnd) begin
        out_b      <= in_data[6:4];
        out_a      <= chain_q ? last_result[2:0]
                              : in_data[2:0];
        out_opcode <= op_q;
      end
      if (fire) begin
        last_result <= alu_z;
        issue_count <= issue_count + 8'd1;
      end
    end
  end

endmodule
